// File: rtl/fmc_pkg.sv
// Shared widths and helpers for the FMC/core BRAM bank arbiter.
package fmc_pkg;

   localparam int unsigned GCNT_W = 4;
   localparam int unsigned WCNT_W = 8;

   // Bank index width; a lone bank still needs a 1-bit select.
   function automatic int unsigned bank_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bram_bank_port.sv
// One BRAM bank: FMC/core/idle port mux plus the post-FMC guard counter.
module bram_bank_port
   import fmc_pkg::*;
#(
   parameter int unsigned AW        = 12,
   parameter int unsigned DW        = 32,
   parameter int unsigned GUARD_CYC = 2
) (
   input  logic          fmc_clk,
   input  logic          rst,
   input  logic          fmc_en,
   input  logic          fmc_we,
   input  logic [AW-1:0] fmc_a,
   input  logic [DW-1:0] fmc_do,
   input  logic          core_sel,
   input  logic          core_we,
   input  logic [AW-1:0] core_a,
   input  logic [DW-1:0] core_do,
   output logic [AW-1:0] bram_a_c,
   output logic [DW-1:0] bram_do_c,
   output logic          bram_en_c,
   output logic          bram_we_c,
   output logic          blocked_c
);

   localparam logic [GCNT_W-1:0] GUARD_LOAD = GCNT_W'(GUARD_CYC);

   logic [GCNT_W-1:0] gcnt;
   logic [GCNT_W-1:0] gcnt_nxt;

   always_ff @(posedge fmc_clk or negedge rst) begin
      if (!rst) gcnt <= '0;
      else      gcnt <= gcnt_nxt;
   end

   // Reload while FMC owns the bank, then count down to free it for the core.
   always_comb begin
      gcnt_nxt = gcnt;
      if (fmc_en)
         gcnt_nxt = GUARD_LOAD;
      else if (gcnt != '0)
         gcnt_nxt = gcnt - GCNT_W'(1);
   end

   assign blocked_c = fmc_en | (gcnt != '0);

   // FMC cannot be stalled, so it always wins the bank it enables.
   always_comb begin
      bram_a_c  = '0;
      bram_do_c = '0;
      bram_en_c = 1'b0;
      bram_we_c = 1'b0;
      if (fmc_en) begin
         bram_a_c  = fmc_a;
         bram_do_c = fmc_do;
         bram_en_c = 1'b1;
         bram_we_c = fmc_we;
      end else if (core_sel) begin
         bram_a_c  = core_a;
         bram_do_c = core_do;
         bram_en_c = 1'b1;
         bram_we_c = core_we;
      end
   end

endmodule

// File: rtl/fmc_bram_arbiter.sv
// Shares BRAM banks between the unstallable FMC bridge and a core requester:
// grant logic, one-cycle read return and a sticky starvation monitor.
module fmc_bram_arbiter
   import fmc_pkg::*;
#(
   parameter int unsigned BRAM_AW   = 12,
   parameter int unsigned DW        = 32,
   parameter int unsigned BRAMS     = 8,
   parameter int unsigned GUARD_CYC = 2,
   parameter int unsigned WAIT_MAX  = 255
) (
   input  logic                        fmc_clk,
   input  logic                        rst,
   input  logic [BRAM_AW-1:0]          fmc_bram_a,
   input  logic [DW-1:0]               fmc_bram_do,
   input  logic [BRAMS-1:0]            fmc_bram_en,
   input  logic                        fmc_bram_we,
   input  logic                        core_req,
   input  logic [bank_w(BRAMS)-1:0]    core_bank,
   input  logic [BRAM_AW-1:0]          core_addr,
   input  logic [DW-1:0]               core_wdata,
   input  logic                        core_we,
   output logic                        core_gnt,
   output logic                        core_rvalid,
   output logic [DW-1:0]               core_rdata,
   output logic                        core_starved,
   input  logic                        core_clr,
   output logic [BRAMS*BRAM_AW-1:0]    bram_a,
   output logic [BRAMS*DW-1:0]         bram_do,
   output logic [BRAMS-1:0]            bram_en,
   output logic [BRAMS-1:0]            bram_we,
   input  logic [BRAMS*DW-1:0]         bram_di
);

   localparam int unsigned       BANK_W = bank_w(BRAMS);
   localparam logic [WCNT_W-1:0] WMAX   = WCNT_W'(WAIT_MAX);

   logic [BRAMS-1:0]  blocked;
   logic [DW-1:0]     di_arr [BRAMS];
   logic              rd_pend;
   logic [BANK_W-1:0] rd_bank;
   logic [WCNT_W-1:0] wcnt;
   logic [WCNT_W-1:0] wcnt_nxt;
   logic              starved_nxt;

   assign core_gnt = core_req & ~blocked[core_bank];

   for (genvar b = 0; b < BRAMS; b++) begin : g_bank
      bram_bank_port #(
         .AW        (BRAM_AW),
         .DW        (DW),
         .GUARD_CYC (GUARD_CYC)
      ) u_port (
         .fmc_clk   (fmc_clk),
         .rst       (rst),
         .fmc_en    (fmc_bram_en[b]),
         .fmc_we    (fmc_bram_we),
         .fmc_a     (fmc_bram_a),
         .fmc_do    (fmc_bram_do),
         .core_sel  (core_gnt && (core_bank == BANK_W'(b))),
         .core_we   (core_we),
         .core_a    (core_addr),
         .core_do   (core_wdata),
         .bram_a_c  (bram_a[b*BRAM_AW +: BRAM_AW]),
         .bram_do_c (bram_do[b*DW +: DW]),
         .bram_en_c (bram_en[b]),
         .bram_we_c (bram_we[b]),
         .blocked_c (blocked[b])
      );
      assign di_arr[b] = bram_di[b*DW +: DW];
   end

   // Read return: the bank is remembered so FMC may take it in the data cycle.
   always_ff @(posedge fmc_clk or negedge rst) begin
      if (!rst) begin
         rd_pend <= 1'b0;
         rd_bank <= '0;
      end else begin
         rd_pend <= core_gnt & ~core_we;
         if (core_gnt && !core_we) rd_bank <= core_bank;
      end
   end

   assign core_rvalid = rd_pend;
   assign core_rdata  = di_arr[rd_bank];

   always_ff @(posedge fmc_clk or negedge rst) begin
      if (!rst) begin
         wcnt         <= '0;
         core_starved <= 1'b0;
      end else begin
         wcnt         <= wcnt_nxt;
         core_starved <= starved_nxt;
      end
   end

   // Clear beats set; the flag latches on the cycle the count hits the limit.
   always_comb begin
      wcnt_nxt    = wcnt;
      starved_nxt = core_starved;
      if (core_clr) begin
         wcnt_nxt    = '0;
         starved_nxt = 1'b0;
      end else if (core_gnt) begin
         wcnt_nxt = '0;
      end else if (core_req) begin
         if (wcnt != WMAX) wcnt_nxt = wcnt + WCNT_W'(1);
         if (wcnt_nxt == WMAX) starved_nxt = 1'b1;
      end
   end

endmodule

// File: doc/fmc_bram_arbiter.md
# fmc_bram_arbiter

Shares the bank of BRAMS dual-role BRAM ports between two masters: the FMC bridge (fmc2bram outputs) and an internal core requester (DSP/DMA engine).
- FMC bursts cannot be stalled (no NWAIT), so FMC has absolute, same-cycle priority on the bank it enables.
- The core gets any other bank through a req/gnt handshake, with a post-FMC guard window and a starvation monitor.
- Sits between fmc2bram and the physical BRAM instances.

## Interface
Parameters:
- BRAM_AW, 12, BRAM word address width
- DW, 32, data width
- BRAMS, 8, number of banks (power of 2, ≥2)
- GUARD_CYC, 2, cycles a bank stays blocked to core after FMC releases it (0..15)
- WAIT_MAX, 255, core wait cycles before starvation flag

Ports:
- fmc_clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- fmc_bram_a  in  BRAM_AW  FMC-side address
- fmc_bram_do  in  DW  FMC write data
- fmc_bram_en  in  BRAMS  FMC bank enables (one-hot or zero)
- fmc_bram_we  in  1  FMC write enable
- core_req  in  1  core access request, held until granted
- core_bank  in  $clog2(BRAMS)  target bank
- core_addr  in  BRAM_AW  core address
- core_wdata  in  DW  core write data
- core_we  in  1  1 = write, 0 = read
- core_gnt  out  1  access accepted this cycle (combinational)
- core_rvalid  out  1  read data valid
- core_rdata  out  DW  read data
- core_starved  out  1  sticky starvation flag
- core_clr  in  1  clears core_starved and wait counter
- bram_a  out  BRAMS*BRAM_AW  per-bank address
- bram_do  out  BRAMS*DW  per-bank write data
- bram_en  out  BRAMS  per-bank enable
- bram_we  out  BRAMS  per-bank write enable
- bram_di  in  BRAMS*DW  per-bank read data; also routed unchanged to fmc2bram

## Operation
- Bank ownership, per bank b:
  - fmc_bram_en[b]=1: bank b driven by FMC inputs, combinationally, zero added latency.
  - Else, core granted to b: driven by core inputs.
  - Else: en=0, we=0, a/do=0.
- Per-bank guard counter gcnt[b] (4 bits):
  - loaded with GUARD_CYC on each cycle fmc_bram_en[b]=1;
  - otherwise decrements to 0.
  - Bank b is blocked to the core while fmc_bram_en[b]=1 or gcnt[b]≠0.
- core_gnt = core_req && bank not blocked.
  - Access issues in the same cycle as the grant.
  - Core holds req/bank/addr/wdata/we stable until gnt.
- Core read:
  - granted read registers rd_pend=1 and rd_bank=core_bank;
  - next cycle core_rvalid=1 and core_rdata = bram_di slice of rd_bank, unregistered;
  - rvalid lasts one cycle per granted read. Back-to-back reads give rvalid every cycle.
- FMC conflict: if fmc_bram_en[core_bank] rises in the cycle the core requests, FMC wins and gnt=0. A core read granted in cycle N still completes in N+1, even if FMC takes the bank in N+1.
- Starvation counter wcnt (8 bits, saturating at WAIT_MAX):
  - increments each cycle core_req && !core_gnt;
  - cleared on gnt or core_clr.
  - core_starved is set when wcnt reaches WAIT_MAX and stays set until core_clr.
  - core_clr has priority over set in the same cycle.
- Reset values: all gcnt=0, wcnt=0, rd_pend=0, core_rvalid=0, core_starved=0. Combinational outputs follow inputs immediately.

## Timing
- FMC path: purely combinational, 0 cycles added.
- Core write: 0-cycle issue on gnt.
- Core read: data 1 cycle after gnt.
- Guard release: bank free to core GUARD_CYC+1 cycles after the last fmc_bram_en[b]=1 cycle. GUARD_CYC=0 gives immediate reuse the next cycle.
- Async reset asserts mid-read: rvalid drops immediately with no spurious rvalid after release.
- fmc_bram_en with >1 bit set is illegal. Each set bit is still serviced independently; the bench asserts against it.

## Structure
- Shared package fmc_pkg holds:
  - bank index width function/localparam
  - GUARD counter width (4)
  - WAIT counter width (8)
- One sub-module, bram_bank_port: a single bank's mux plus its guard counter. It is instantiated BRAMS times by generate.
- Top level holds grant logic, read-return register and starvation monitor.

## Test plan
- Core write idle: no FMC; core_req bank 3, addr 0x010, wdata 0xA5A5A5A5, we=1 -> gnt same cycle, bram_en[3]=bram_we[3]=1, bram_a slice 3 = 0x010, all other banks idle.
- Core read latency: read bank 0 addr 0x7FF -> gnt cycle N, core_rvalid only at N+1 with core_rdata = bram_di[31:0].
- FMC preemption: FMC burst on bank 2 while core_req to bank 2 -> gnt=0 throughout the burst and for 2 further cycles (GUARD_CYC=2), then gnt. A simultaneous core request to bank 5 is granted immediately.
- Simultaneous arrival: fmc_bram_en[1] and core_req bank 1 rise together -> FMC drives bank 1, core_gnt=0.
- Starvation: core blocked by FMC on bank 4 for 300 cycles -> core_starved=1 at wait cycle 255 and held. core_clr -> flag 0 and wcnt 0 next cycle.
- Reset mid-read: rst low the cycle after a read gnt -> core_rvalid=0 immediately, gcnt/wcnt zero, no rvalid after release.
